fpu_request_scheduler: RTL and testbench

Shares one combinational FPU datapath (add/mul, 32-bit IEEE-754 operands, control 0=add, 1=mul) between NUM_REQ requesters.
- Arbitrates round-robin and registers the winning operands.
- Holds the FPU inputs stable for a fixed multicycle window, then captures the result.
- Returns the result on a valid/ready response channel tagged with the requester index.
- Sits between the issuing units and the shared FPU instance.

---
 rtl/fpu_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/fpu_request_scheduler.sv | 136 +++++++++++++
 tb/tb_fpu_request_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU request scheduler.
package fpu_sched_pkg;

   localparam int unsigned FP_W = 32;

   // FPU control encoding
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_req
);

   logic            found;
   logic [ID_W-1:0] idx;

   assign any_req = |req;

   // Cyclic scan from ptr; the first hit wins and masks the rest.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((32'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/fpu_request_scheduler.sv
// Round-robin scheduler sharing one combinational FPU between NUM_REQ requesters.
// Operands are held for EXEC_CYCLES cycles, then the result is returned on a
// valid/ready channel tagged with the owning requester index.
module fpu_request_scheduler
   import fpu_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned EXEC_CYCLES = 2,
   parameter int unsigned ID_W        = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ-1:0]      req_op,
   input  logic [FP_W*NUM_REQ-1:0] req_a,
   input  logic [FP_W*NUM_REQ-1:0] req_b,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [FP_W-1:0]         resp_result,
   output logic [FP_W-1:0]         fpu_a,
   output logic [FP_W-1:0]         fpu_b,
   output logic                    fpu_control,
   input  logic [FP_W-1:0]         fpu_result,
   output logic                    busy
);

   localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FP_W-1:0]    op_a_q, op_a_d;
   logic [FP_W-1:0]    op_b_q, op_b_d;
   logic               op_ctl_q, op_ctl_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [FP_W-1:0]    result_q, result_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               any_req;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // Next-state logic: grant and latch in IDLE, count down in EXEC, wait for handshake in RESP.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      op_ctl_d  = op_ctl_q;
      id_d      = id_q;
      result_d  = result_q;
      req_ready = '0;
      unique case (state_q)
         StIdle: begin
            if (any_req && !rst) begin
               req_ready = grant;
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  if (grant[i]) begin
                     op_a_d   = req_a[i*FP_W +: FP_W];
                     op_b_d   = req_b[i*FP_W +: FP_W];
                     op_ctl_d = req_op[i];
                  end
               end
               id_d = grant_idx;
               if (32'(grant_idx) == NUM_REQ - 1) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = grant_idx + 1'b1;
               end
               cnt_d   = CNT_W'(EXEC_CYCLES - 1);
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_q == '0) begin
               result_d = fpu_result;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         cnt_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_ctl_q <= 1'b0;
         id_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_ctl_q <= op_ctl_d;
         id_q     <= id_d;
         result_q <= result_d;
      end
   end

   // FPU inputs come straight from the operand registers so they stay stable through EXEC.
   assign fpu_a       = op_a_q;
   assign fpu_b       = op_b_q;
   assign fpu_control = op_ctl_q;
   assign resp_valid  = (state_q == StResp);
   assign resp_id     = id_q;
   assign resp_result = result_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_request_scheduler.sv
// Scoreboard bench for fpu_request_scheduler: main instance (EXEC_CYCLES=2) plus
// EXEC_CYCLES=1 and EXEC_CYCLES=4 instances driven by a cycle-count FPU stub.
module tb_fpu_request_scheduler;
   import fpu_sched_pkg::*;

   typedef struct packed {
      logic [0:0]  id;
      logic [31:0] res;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req_op;
   logic [63:0] req_a, req_b;
   logic        resp_valid, resp_ready, fpu_control, busy;
   logic [0:0]  resp_id;
   logic [31:0] resp_result, fpu_a, fpu_b, fpu_result;

   logic [1:0]  w_valid, w_op, d1_ready, d4_ready;
   logic [63:0] w_a, w_b;
   logic        d1_rvalid, d1_rready, d1_fc, d1_busy, d4_rvalid, d4_rready, d4_fc, d4_busy;
   logic [0:0]  d1_id, d4_id;
   logic [31:0] d1_res, d1_fa, d1_fb, d4_res, d4_fa, d4_fb, cyc_w;

   int   mode;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   model_ptr = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign cyc_w = 32'(cyc);

   // FPU stub: 0 = a^b, 1 = small IEEE lookup, otherwise the free-running cycle count
   always_comb begin
      fpu_result = 32'hFFFF_FFFF;
      if (mode == 0) begin
         fpu_result = fpu_a ^ fpu_b;
      end else if (mode == 1) begin
         if (fpu_a == 32'h4000_0000 && fpu_b == 32'h4040_0000)
            fpu_result = (fpu_control == OP_MUL) ? 32'h40C0_0000 : 32'h40A0_0000;
      end else begin
         fpu_result = cyc_w;
      end
   end

   fpu_request_scheduler #(.NUM_REQ(2), .EXEC_CYCLES(2), .ID_W(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_result(resp_result), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_control(fpu_control), .fpu_result(fpu_result), .busy(busy)
   );

   fpu_request_scheduler #(.NUM_REQ(2), .EXEC_CYCLES(1), .ID_W(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(w_valid), .req_ready(d1_ready), .req_op(w_op),
      .req_a(w_a), .req_b(w_b), .resp_valid(d1_rvalid), .resp_ready(d1_rready),
      .resp_id(d1_id), .resp_result(d1_res), .fpu_a(d1_fa), .fpu_b(d1_fb),
      .fpu_control(d1_fc), .fpu_result(cyc_w), .busy(d1_busy)
   );

   fpu_request_scheduler #(.NUM_REQ(2), .EXEC_CYCLES(4), .ID_W(1)) dut4 (
      .clk(clk), .rst(rst), .req_valid(w_valid), .req_ready(d4_ready), .req_op(w_op),
      .req_a(w_a), .req_b(w_b), .resp_valid(d4_rvalid), .resp_ready(d4_rready),
      .resp_id(d4_id), .resp_result(d4_res), .fpu_a(d4_fa), .fpu_b(d4_fb),
      .fpu_control(d4_fc), .fpu_result(cyc_w), .busy(d4_busy)
   );

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         if (|req_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_resp(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++; $display("FAIL %s_sb: got empty scoreboard, want one entry", tag);
         return;
      end
      e = sbq.pop_front();
      if (resp_id !== e.id || resp_result !== e.res) begin
         errors++;
         $display("FAIL %s_resp: got id=%0d res=%h, want id=%0d res=%h", tag, resp_id,
                  resp_result, e.id, e.res);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
      w_valid = '0; w_op = '0; w_a = '0; w_b = '0; d1_rready = 1'b0; d4_rready = 1'b0; mode = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, resp_valid, req_ready} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl: got %b, want 0000", {busy, resp_valid, req_ready});
      end
      checks++;
      if ({fpu_a, fpu_b, fpu_control, resp_result, resp_id} !== '0) begin
         errors++; $display("FAIL reset_data: got a=%h b=%h c=%b r=%h id=%0d, want all 0",
                            fpu_a, fpu_b, fpu_control, resp_result, resp_id);
      end
      checks++;
      if ({d1_busy, d4_busy} !== 2'b00) begin
         errors++; $display("FAIL reset_busy_alt: got %b, want 00", {d1_busy, d4_busy});
      end
      model_ptr = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      mode = 1; resp_ready = 1'b1;
      req_valid = 2'b01; req_op = 2'b01;
      req_a[31:0] = 32'h4000_0000; req_b[31:0] = 32'h4040_0000;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01 || busy !== 1'b0) begin
         errors++; $display("FAIL mul_grant: got ready=%b busy=%b, want 01/0", req_ready, busy);
      end
      sbq.push_back('{id: 1'b0, res: 32'h40C0_0000});
      model_ptr = 1;
      @(posedge clk); #1 req_valid = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || resp_valid !== (k == 3)) begin
            errors++; $display("FAIL mul_cycle%0d: got busy=%b rv=%b, want 1/%b", k, busy,
                               resp_valid, (k == 3));
         end
         if (k < 3) begin
            checks++;
            if ({fpu_a, fpu_b, fpu_control} !== {32'h4000_0000, 32'h4040_0000, OP_MUL}) begin
               errors++; $display("FAIL mul_fpu_in: got a=%h b=%h c=%b, want 40000000 40400000 1",
                                  fpu_a, fpu_b, fpu_control);
            end
         end else begin
            pop_compare("mul");
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL mul_done: got busy=%b rv=%b, want 0/0", busy, resp_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      bit ok;
      int g;
      int last_cyc = 0;
      mode = 0; resp_ready = 1'b1; req_op = 2'b00;
      req_a = {32'h1357_9BDF, 32'h1111_0000}; req_b = {32'h0F0F_0F0F, 32'h0000_2222};
      req_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_grant(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rr_grant%0d: got no grant, want grant within 16 cycles", n);
            break;
         end
         g = model_ptr;
         checks++;
         if (req_ready !== 2'(1 << g)) begin
            errors++; $display("FAIL rr_order%0d: got ready=%b, want %b", n, req_ready, 2'(1 << g));
         end
         if (n > 0) begin
            checks++;
            if (cyc - last_cyc !== 4) begin
               errors++; $display("FAIL rr_period%0d: got %0d cycles, want 4", n, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         sbq.push_back('{id: 1'(g), res: req_a[g*32 +: 32] ^ req_b[g*32 +: 32]});
         model_ptr = (g + 1) % 2;
         @(posedge clk); #1;
         req_a[g*32 +: 32] = $urandom();
         req_b[g*32 +: 32] = $urandom();
         wait_resp(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rr_resp_to%0d: got no resp_valid, want one", n);
            break;
         end
         pop_compare("rr");
      end
      @(posedge clk); #1 req_valid = '0;
      sbq.delete();
   endtask

   task automatic test_backpressure();
      bit ok;
      exp_t e;
      mode = 0; resp_ready = 1'b0;
      req_a[63:32] = 32'hA5A5_0001; req_b[63:32] = 32'h0000_FFFF; req_valid = 2'b10;
      wait_grant(ok);
      checks++;
      if (!ok || req_ready !== 2'b10) begin
         errors++; $display("FAIL bp_grant: got ready=%b, want 10", req_ready);
      end
      e = '{id: 1'b1, res: 32'hA5A5_0001 ^ 32'h0000_FFFF};
      model_ptr = 0;
      @(posedge clk); #1 req_valid = 2'b11;
      wait_resp(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL bp_resp_to: got no resp_valid, want one");
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b1 || resp_result !== e.res || resp_id !== e.id
             || req_ready !== 2'b00) begin
            errors++; $display("FAIL bp_hold%0d: got rv=%b res=%h id=%0d rdy=%b, want 1 %h %0d 00",
                               k, resp_valid, resp_result, resp_id, req_ready, e.res, e.id);
         end
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_result !== e.res) begin
         errors++; $display("FAIL bp_release: got busy=%b rv=%b res=%h, want 0 0 %h", busy,
                            resp_valid, resp_result, e.res);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 1'b0;
      mode = 0; resp_ready = 1'b1;
      req_a[31:0] = 32'h0BAD_F00D; req_b[31:0] = 32'h1234_5678; req_valid = 2'b01;
      wait_grant(ok);
      checks++;
      if (!ok || req_ready !== 2'b01) begin
         errors++; $display("FAIL rm_grant: got ready=%b, want 01", req_ready);
      end
      @(posedge clk); #1 req_valid = '0; rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({busy, resp_valid, req_ready, fpu_a, fpu_b, fpu_control, resp_result, resp_id} !== '0)
      begin
         errors++; $display("FAIL rm_outputs: got busy=%b rv=%b a=%h b=%h r=%h id=%0d, want all 0",
                            busy, resp_valid, fpu_a, fpu_b, resp_result, resp_id);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rm_ghost_resp: got resp_valid=1, want none after abort");
      end
      model_ptr = 0;
      @(posedge clk); #1 req_valid = 2'b11;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL rm_prio: got ready=%b, want 01", req_ready);
      end
      sbq.push_back('{id: 1'b0, res: req_a[31:0] ^ req_b[31:0]});
      model_ptr = 1;
      @(posedge clk); #1 req_valid = '0;
      wait_resp(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rm_resp_to: got no resp_valid, want one");
      end
      pop_compare("rm");
      @(posedge clk); #1;
   endtask

   task automatic test_pulse();
      bit ok;
      mode = 0; resp_ready = 1'b1;
      req_a = {32'h2222_0000, 32'h0000_3333}; req_b = {32'h0000_4444, 32'h5555_0000};
      req_valid = 2'b01;
      wait_grant(ok);
      checks++;
      if (!ok || req_ready !== 2'b01) begin
         errors++; $display("FAIL pulse_grant: got ready=%b, want 01", req_ready);
      end
      sbq.push_back('{id: 1'b0, res: 32'h0000_3333 ^ 32'h5555_0000});
      model_ptr = 1;
      @(posedge clk); #1 req_valid = 2'b10;
      @(posedge clk); #1 req_valid = 2'b00;
      wait_resp(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL pulse_resp_to: got no resp_valid, want one");
      end
      pop_compare("pulse");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 2'b00 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL pulse_lost%0d: got rdy=%b busy=%b rv=%b, want 00 0 0", k,
                               req_ready, busy, resp_valid);
         end
      end
      @(posedge clk); #1 req_valid = 2'b11;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'(1 << model_ptr)) begin
         errors++; $display("FAIL pulse_ptr: got ready=%b, want %b", req_ready,
                            2'(1 << model_ptr));
      end
      @(posedge clk); #1 req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_exec_window();
      int c0;
      exp_t e1, e4;
      w_op = 2'b01; w_a[31:0] = 32'hCAFE_0001; w_b[31:0] = 32'h0000_BEEF; w_valid = 2'b01;
      d1_rready = 1'b0; d4_rready = 1'b0;
      @(negedge clk);
      checks++;
      if (d1_ready !== 2'b01 || d4_ready !== 2'b01) begin
         errors++; $display("FAIL ew_grant: got d1=%b d4=%b, want 01 01", d1_ready, d4_ready);
      end
      c0 = cyc;
      sbq.push_back('{id: 1'b0, res: 32'(c0 + 1)});
      sbq.push_back('{id: 1'b0, res: 32'(c0 + 4)});
      @(posedge clk); #1 w_valid = '0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (d1_rvalid !== (k >= 2) || d4_rvalid !== (k >= 5) || d4_busy !== 1'b1) begin
            errors++; $display("FAIL ew_cycle%0d: got rv1=%b rv4=%b busy4=%b, want %b %b 1", k,
                               d1_rvalid, d4_rvalid, d4_busy, (k >= 2), (k >= 5));
         end
         if (k == 1) begin
            checks++;
            if ({d1_fa, d1_fb, d1_fc, d4_fa, d4_fb, d4_fc}
                !== {32'hCAFE_0001, 32'h0000_BEEF, OP_MUL, 32'hCAFE_0001, 32'h0000_BEEF, OP_MUL})
            begin
               errors++; $display("FAIL ew_fpu_in: got d1 a=%h b=%h d4 a=%h b=%h, want cafe0001 0000beef",
                                  d1_fa, d1_fb, d4_fa, d4_fb);
            end
         end
      end
      e1 = sbq.pop_front();
      e4 = sbq.pop_front();
      checks++;
      if (d1_res !== e1.res || d1_id !== e1.id) begin
         errors++; $display("FAIL ew_res1: got res=%h id=%0d, want %h %0d", d1_res, d1_id,
                            e1.res, e1.id);
      end
      checks++;
      if (d4_res !== e4.res || d4_id !== e4.id) begin
         errors++; $display("FAIL ew_res4: got res=%h id=%0d, want %h %0d", d4_res, d4_id,
                            e4.res, e4.id);
      end
      @(posedge clk); #1 d1_rready = 1'b1; d4_rready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({d1_rvalid, d1_busy, d4_rvalid, d4_busy} !== 4'b0) begin
         errors++; $display("FAIL ew_release: got %b, want 0000",
                            {d1_rvalid, d1_busy, d4_rvalid, d4_busy});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_pulse();
      test_exec_window();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
